// File: rtl/esdi_pkg.sv
// Shared types and constants for the ESDI read path: sequencer states, status codes,
// the ID-field layout and the default sync byte.
package esdi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_SECTOR,
        ST_GATE_DLY,
        ST_HDR_SYNC,
        ST_HDR_ID,
        ST_DATA_SYNC,
        ST_DATA,
        ST_DONE
    } esdi_state_e;

    localparam logic [1:0] STATUS_OK                = 2'd0;
    localparam logic [1:0] STATUS_NOT_FOUND         = 2'd1;
    localparam logic [1:0] STATUS_DATA_SYNC_TIMEOUT = 2'd2;
    localparam logic [1:0] STATUS_ABORTED           = 2'd3;

    localparam int unsigned ESDI_ID_BYTES  = 4;
    localparam logic [7:0]  ESDI_SYNC_BYTE = 8'hA1;

    typedef struct packed {
        logic [11:0] cyl;
        logic [3:0]  head;
        logic [7:0]  sector;
    } esdi_addr_t;

    // Expected ID-field byte at position idx, in on-disk order.
    function automatic logic [7:0] id_byte(input esdi_addr_t a, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = {4'h0, a.cyl[11:8]};
            2'd1:    b = a.cyl[7:0];
            2'd2:    b = {4'h0, a.head};
            default: b = a.sector;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/esdi_sync_edge.sv
// Two-flop synchronizer for an asynchronous drive strobe with a rising-edge pulse output.
module esdi_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise_c
);

    // [0],[1] synchronize; [2] holds the previous synchronized level for edge detect.
    logic [2:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], async_in};
        end
    end

    assign rise_c = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/esdi_read_sequencer.sv
// Sequences one ESDI sector read: sector pulse -> read gate -> header sync/ID match ->
// data sync -> one sector forwarded downstream with tlast.
module esdi_read_sequencer
    import esdi_pkg::*;
#(
    parameter int unsigned GATE_DELAY   = 16,
    parameter logic [7:0]  SYNC_BYTE    = ESDI_SYNC_BYTE,
    parameter int unsigned SECTOR_BYTES = 512,
    parameter int unsigned SYNC_TIMEOUT = 32,
    parameter int unsigned MAX_MISSES   = 64
) (
    input  logic        csr_aclk,
    input  logic        csr_areset,
    input  logic        start,
    input  logic        abort,
    input  logic [11:0] target_cyl,
    input  logic [3:0]  target_head,
    input  logic [7:0]  target_sector,
    input  logic        esdi_sector,
    input  logic        parallel_tvalid,
    output logic        parallel_tready,
    input  logic [7:0]  parallel_tdata,
    output logic        esdi_read_gate,
    output logic        gate_for_header,
    output logic        gate_for_data,
    output logic        sector_tvalid,
    input  logic        sector_tready,
    output logic [7:0]  sector_tdata,
    output logic        sector_tlast,
    output logic        busy,
    output logic        done,
    output logic [1:0]  status
);

    localparam int unsigned BYTE_W = 10;
    localparam int unsigned MISS_W = $clog2(MAX_MISSES + 1);
    localparam int unsigned DLY_W  = $clog2(GATE_DELAY + 1);
    localparam int unsigned TO_W   = $clog2(SYNC_TIMEOUT + 1);

    esdi_state_e        state_q, state_d;
    esdi_addr_t         target_q;
    logic [MISS_W-1:0]  miss_q;
    logic [MISS_W-1:0]  miss_inc_c;
    logic [DLY_W-1:0]   dly_q;
    logic [TO_W-1:0]    to_q;
    logic [BYTE_W-1:0]  byte_q;
    logic [1:0]         status_d;
    logic [7:0]         id_exp_c;
    logic               sector_rise_c;
    logic               byte_acc_c;
    logic               out_acc_c;
    logic               state_chg_c;

    esdi_sync_edge u_sector_sync (
        .clk      (csr_aclk),
        .rst      (csr_areset),
        .async_in (esdi_sector),
        .rise_c   (sector_rise_c)
    );

    // Input stalls only while the one-deep output register is full and blocked.
    assign parallel_tready = (state_q != ST_DATA) || !sector_tvalid || sector_tready;
    assign byte_acc_c      = parallel_tvalid && parallel_tready;
    assign out_acc_c       = sector_tvalid && sector_tready;
    assign state_chg_c     = (state_d != state_q);
    assign miss_inc_c      = miss_q + MISS_W'(1);
    assign id_exp_c        = id_byte(target_q, byte_q[1:0]);

    always_ff @(posedge csr_aclk or posedge csr_areset) begin
        if (csr_areset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and the status code that goes with the DONE entry.
    always_comb begin
        state_d  = state_q;
        status_d = status;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_WAIT_SECTOR;
                    status_d = STATUS_OK;
                end
            end
            ST_WAIT_SECTOR: begin
                if (sector_rise_c) begin
                    if (miss_inc_c == MISS_W'(MAX_MISSES)) begin
                        state_d  = ST_DONE;
                        status_d = STATUS_NOT_FOUND;
                    end else begin
                        state_d = ST_GATE_DLY;
                    end
                end
            end
            ST_GATE_DLY: begin
                if (dly_q == DLY_W'(GATE_DELAY)) begin
                    state_d = ST_HDR_SYNC;
                end
            end
            ST_HDR_SYNC: begin
                if (byte_acc_c) begin
                    if (parallel_tdata == SYNC_BYTE) begin
                        state_d = ST_HDR_ID;
                    end else if (to_q == TO_W'(SYNC_TIMEOUT - 1)) begin
                        state_d = ST_WAIT_SECTOR;
                    end
                end
            end
            ST_HDR_ID: begin
                if (byte_acc_c) begin
                    if (parallel_tdata != id_exp_c) begin
                        state_d = ST_WAIT_SECTOR;
                    end else if (byte_q == BYTE_W'(ESDI_ID_BYTES - 1)) begin
                        state_d = ST_DATA_SYNC;
                    end
                end
            end
            ST_DATA_SYNC: begin
                if (byte_acc_c) begin
                    if (parallel_tdata == SYNC_BYTE) begin
                        state_d = ST_DATA;
                    end else if (to_q == TO_W'(SYNC_TIMEOUT - 1)) begin
                        state_d  = ST_DONE;
                        status_d = STATUS_DATA_SYNC_TIMEOUT;
                    end
                end
            end
            ST_DATA: begin
                if (out_acc_c && sector_tlast) begin
                    state_d  = ST_DONE;
                    status_d = STATUS_OK;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort && (state_q != ST_IDLE) && (state_q != ST_DONE)) begin
            state_d  = ST_DONE;
            status_d = STATUS_ABORTED;
        end
    end

    // Target latch, miss counter (per command) and per-state counters (cleared on entry).
    always_ff @(posedge csr_aclk or posedge csr_areset) begin
        if (csr_areset) begin
            target_q <= '0;
            miss_q   <= '0;
            dly_q    <= '0;
            to_q     <= '0;
            byte_q   <= '0;
        end else begin
            if ((state_q == ST_IDLE) && start) begin
                target_q <= {target_cyl, target_head, target_sector};
                miss_q   <= '0;
            end else if ((state_q == ST_WAIT_SECTOR) && sector_rise_c) begin
                miss_q <= miss_inc_c;
            end
            if (state_chg_c) begin
                dly_q  <= '0;
                to_q   <= '0;
                byte_q <= '0;
            end else begin
                if (state_q == ST_GATE_DLY) begin
                    dly_q <= dly_q + DLY_W'(1);
                end
                if (byte_acc_c && ((state_q == ST_HDR_SYNC) || (state_q == ST_DATA_SYNC))) begin
                    to_q <= to_q + TO_W'(1);
                end
                if (byte_acc_c && ((state_q == ST_HDR_ID) ||
                    ((state_q == ST_DATA) && (byte_q < BYTE_W'(SECTOR_BYTES))))) begin
                    byte_q <= byte_q + BYTE_W'(1);
                end
            end
        end
    end

    // Registered outputs, decoded from the state being entered.
    always_ff @(posedge csr_aclk or posedge csr_areset) begin
        if (csr_areset) begin
            esdi_read_gate  <= 1'b0;
            gate_for_header <= 1'b0;
            gate_for_data   <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            status          <= STATUS_OK;
            sector_tvalid   <= 1'b0;
            sector_tdata    <= '0;
            sector_tlast    <= 1'b0;
        end else begin
            esdi_read_gate  <= state_d inside {ST_HDR_SYNC, ST_HDR_ID, ST_DATA_SYNC, ST_DATA};
            gate_for_header <= state_d inside {ST_HDR_SYNC, ST_HDR_ID};
            gate_for_data   <= state_d inside {ST_DATA_SYNC, ST_DATA};
            busy            <= (state_d != ST_IDLE);
            done            <= (state_d == ST_DONE);
            status          <= status_d;
            if (state_d != ST_DATA) begin
                sector_tvalid <= 1'b0;
                sector_tlast  <= 1'b0;
            end else if ((state_q == ST_DATA) && byte_acc_c &&
                         (byte_q < BYTE_W'(SECTOR_BYTES))) begin
                sector_tvalid <= 1'b1;
                sector_tdata  <= parallel_tdata;
                sector_tlast  <= (byte_q == BYTE_W'(SECTOR_BYTES - 1));
            end else if (sector_tready) begin
                sector_tvalid <= 1'b0;
                sector_tlast  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_esdi_read_sequencer.sv
// Directed bench for esdi_read_sequencer: payload bytes are queued as they enter the
// datapath and checked in order as beats leave the sector port.
module tb_esdi_read_sequencer;
    import esdi_pkg::*;

    logic        csr_aclk = 1'b0;
    logic        csr_areset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [11:0] target_cyl = '0;
    logic [3:0]  target_head = '0;
    logic [7:0]  target_sector = '0;
    logic        esdi_sector = 1'b0;
    logic        parallel_tvalid = 1'b0;
    logic        parallel_tready;
    logic [7:0]  parallel_tdata = '0;
    logic        esdi_read_gate;
    logic        gate_for_header;
    logic        gate_for_data;
    logic        sector_tvalid;
    logic        sector_tready = 1'b1;
    logic [7:0]  sector_tdata;
    logic        sector_tlast;
    logic        busy;
    logic        done;
    logic [1:0]  status;

    int          vectors = 0;
    int          miscompares = 0;
    int          beats = 0;
    int          cyc = 0;
    bit          bp_mode = 1'b0;
    bit          any_valid = 1'b0;
    logic [8:0]  sb_q[$];
    logic [8:0]  want;
    int          k;

    esdi_read_sequencer dut (
        .csr_aclk        (csr_aclk),
        .csr_areset      (csr_areset),
        .start           (start),
        .abort           (abort),
        .target_cyl      (target_cyl),
        .target_head     (target_head),
        .target_sector   (target_sector),
        .esdi_sector     (esdi_sector),
        .parallel_tvalid (parallel_tvalid),
        .parallel_tready (parallel_tready),
        .parallel_tdata  (parallel_tdata),
        .esdi_read_gate  (esdi_read_gate),
        .gate_for_header (gate_for_header),
        .gate_for_data   (gate_for_data),
        .sector_tvalid   (sector_tvalid),
        .sector_tready   (sector_tready),
        .sector_tdata    (sector_tdata),
        .sector_tlast    (sector_tlast),
        .busy            (busy),
        .done            (done),
        .status          (status)
    );

    always #5 csr_aclk = ~csr_aclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Downstream sink: every accepted beat must be the next queued byte.
    always @(negedge csr_aclk) begin
        if (sector_tvalid) any_valid = 1'b1;
        if (!csr_areset && sector_tvalid && sector_tready) begin
            beats++;
            vectors++;
            assert (sb_q.size() != 0) else begin
                miscompares++;
                $error("FAIL unexpected_beat: observed data %0h expected no beat", sector_tdata);
            end
            if (sb_q.size() != 0) begin
                want = sb_q.pop_front();
                check("beat_data", 32'(sector_tdata), 32'(want[7:0]));
                check("beat_last", 32'(sector_tlast), 32'(want[8]));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge csr_aclk);
        #1;
        cyc++;
        sector_tready = bp_mode ? (cyc % 3 == 0) : 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit acc;
        acc = 1'b0;
        parallel_tvalid = 1'b1;
        parallel_tdata  = b;
        for (int i = 0; i < 64 && !acc; i++) begin
            @(negedge csr_aclk);
            acc = parallel_tready;
            if (bp_mode && sector_tvalid && !sector_tready)
                check("stall_tready", 32'(parallel_tready), 32'd0);
            tick();
        end
        parallel_tvalid = 1'b0;
        check("byte_accept", 32'(acc), 32'd1);
    endtask

    task automatic do_start(input logic [11:0] c, input logic [3:0] h, input logic [7:0] s);
        target_cyl    = c;
        target_head   = h;
        target_sector = s;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic pulse_gate(output int kk);
        kk = -1;
        esdi_sector = 1'b1;
        for (int i = 1; i <= 40 && kk < 0; i++) begin
            tick();
            if (i == 4) esdi_sector = 1'b0;
            if (esdi_read_gate) kk = i;
        end
        esdi_sector = 1'b0;
    endtask

    task automatic send_header(input logic [11:0] c, input logic [3:0] h, input logic [7:0] s);
        send_byte(8'hA1);
        send_byte({4'h0, c[11:8]});
        send_byte(c[7:0]);
        send_byte({4'h0, h});
        send_byte(s);
    endtask

    task automatic run_data(input int n);
        send_byte(8'h55);
        send_byte(8'h66);
        send_byte(8'h77);
        send_byte(8'hA1);
        for (int i = 0; i < n; i++) begin
            send_byte(8'(i));
            sb_q.push_back({(i == 511), 8'(i)});
        end
    endtask

    task automatic wait_done(input int budget, input logic [1:0] want_status, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (done) seen = 1'b1;
            else tick();
        end
        check({tag, "_done"}, 32'(seen), 32'd1);
        check({tag, "_status"}, 32'(status), 32'(want_status));
        tick();
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_status_held"}, 32'(status), 32'(want_status));
    endtask

    initial begin
        // Reset values
        tick();
        tick();
        check("rst_ptready", 32'(parallel_tready), 32'd1);
        check("rst_read_gate", 32'(esdi_read_gate), 32'd0);
        check("rst_gate_hdr", 32'(gate_for_header), 32'd0);
        check("rst_gate_data", 32'(gate_for_data), 32'd0);
        check("rst_tvalid", 32'(sector_tvalid), 32'd0);
        check("rst_tlast", 32'(sector_tlast), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_status", 32'(status), 32'd0);
        csr_areset = 1'b0;
        tick();

        // Match on first pulse
        do_start(12'h123, 4'h5, 8'h07);
        beats = 0;
        pulse_gate(k);
        check("t1_gate_delay", 32'(k), 32'd20);
        check("t1_gate_hdr", 32'(gate_for_header), 32'd1);
        send_header(12'h123, 4'h5, 8'h07);
        check("t1_gate_data", 32'(gate_for_data), 32'd1);
        check("t1_gate_hdr_off", 32'(gate_for_header), 32'd0);
        run_data(512);
        wait_done(20, STATUS_OK, "t1");
        check("t1_beats", 32'(beats), 32'd512);

        // Match on third pulse
        do_start(12'h123, 4'h5, 8'h07);
        beats = 0;
        for (int s = 5; s <= 6; s++) begin
            pulse_gate(k);
            check("t2_gate_delay", 32'(k), 32'd20);
            send_header(12'h123, 4'h5, 8'(s));
            check("t2_gate_fall", 32'(esdi_read_gate), 32'd0);
        end
        pulse_gate(k);
        check("t2_gate_delay", 32'(k), 32'd20);
        send_header(12'h123, 4'h5, 8'h07);
        run_data(512);
        wait_done(20, STATUS_OK, "t2");
        check("t2_beats", 32'(beats), 32'd512);

        // Not found after 64 pulses
        do_start(12'h123, 4'h5, 8'h07);
        any_valid = 1'b0;
        for (int p = 1; p < 64; p++) begin
            pulse_gate(k);
            check("t3_gate_delay", 32'(k), 32'd20);
            send_header(12'h123, 4'h5, 8'h09);
        end
        esdi_sector = 1'b1;
        wait_done(10, STATUS_NOT_FOUND, "t3");
        esdi_sector = 1'b0;
        tick();
        check("t3_no_tvalid", 32'(any_valid), 32'd0);

        // Data sync timeout
        do_start(12'h123, 4'h5, 8'h07);
        pulse_gate(k);
        check("t4_gate_delay", 32'(k), 32'd20);
        send_header(12'h123, 4'h5, 8'h07);
        for (int i = 0; i < 31; i++) send_byte(8'h00);
        check("t4_not_yet_done", 32'(done), 32'd0);
        send_byte(8'h00);
        check("t4_done", 32'(done), 32'd1);
        check("t4_status", 32'(status), 32'(STATUS_DATA_SYNC_TIMEOUT));
        check("t4_gate_data", 32'(gate_for_data), 32'd0);
        check("t4_read_gate", 32'(esdi_read_gate), 32'd0);
        tick();
        check("t4_idle", 32'(busy), 32'd0);

        // Backpressure
        bp_mode = 1'b1;
        do_start(12'h123, 4'h5, 8'h07);
        beats = 0;
        pulse_gate(k);
        check("t5_gate_delay", 32'(k), 32'd20);
        send_header(12'h123, 4'h5, 8'h07);
        run_data(512);
        wait_done(20, STATUS_OK, "t5");
        check("t5_beats", 32'(beats), 32'd512);
        bp_mode = 1'b0;
        tick();

        // Abort at data byte 100; a start while busy is ignored
        do_start(12'h123, 4'h5, 8'h07);
        beats = 0;
        tick();
        do_start(12'h000, 4'h0, 8'h00);
        pulse_gate(k);
        check("t6_gate_delay", 32'(k), 32'd20);
        send_header(12'h123, 4'h5, 8'h07);
        run_data(100);
        abort = 1'b1;
        tick();
        check("t6_done", 32'(done), 32'd1);
        check("t6_status", 32'(status), 32'(STATUS_ABORTED));
        check("t6_tvalid", 32'(sector_tvalid), 32'd0);
        check("t6_tlast", 32'(sector_tlast), 32'd0);
        abort = 1'b0;
        tick();
        check("t6_idle", 32'(busy), 32'd0);
        check("t6_sb_empty", 32'(sb_q.size()), 32'd0);
        check("t6_beats", 32'(beats), 32'd100);

        // Reset mid-command
        do_start(12'h123, 4'h5, 8'h07);
        pulse_gate(k);
        check("t7_gate_up", 32'(esdi_read_gate), 32'd1);
        csr_areset = 1'b1;
        #1;
        check("t7_gate_down", 32'(esdi_read_gate), 32'd0);
        check("t7_busy", 32'(busy), 32'd0);
        check("t7_done", 32'(done), 32'd0);
        tick();
        csr_areset = 1'b0;
        tick();
        check("t7_no_done", 32'(done), 32'd0);
        check("t7_ptready", 32'(parallel_tready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
